// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl - stall/flush sequencer for the five-stage DLX pipeline.
// Detects load-use hazards, taken branches and data-memory wait states, and
// drives hold/flush controls to IF/ID, ID/EX, EX/MEM, MEM/WB and the PC.
// A three-state FSM (RUN, LOAD_STALL, MEM_WAIT) sequences multi-cycle stalls
// and the forced release after MEM_TIMEOUT wait cycles.
// Optional: define HAZARD_PERF_CNT_EN to add the stall_cycles/flush_events
// performance counters.
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_WIDTH    = 5,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int MEM_TIMEOUT       = 15
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
    input  logic                      id_rs1_used,
    input  logic                      id_rs2_used,
    input  logic                      ex_mem_rd_en,
    input  logic [REG_ADDR_WIDTH-1:0] ex_reg_wr_addr,
    input  logic                      mem_req,
    input  logic                      mem_ack,
    input  logic                      branch_taken,
    output logic                      pc_hold,
    output logic                      ifid_hold,
    output logic                      ifid_flush,
    output logic                      idex_hold,
    output logic                      idex_flush,
    output logic                      exmem_hold,
    output logic                      exmem_flush,
    output logic                      memwb_flush,
    output logic                      mem_timeout,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]               stall_cycles,
    output logic [31:0]               flush_events,
`endif
    output logic [1:0]                hazard_state
);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_MEM_WAIT   = 2'd2
    } state_t;

    typedef struct packed {
        logic pc_hold;
        logic ifid_hold;
        logic ifid_flush;
        logic idex_hold;
        logic idex_flush;
        logic exmem_hold;
        logic exmem_flush;
        logic memwb_flush;
        logic mem_timeout;
    } ctl_t;

    // Control patterns; hold and flush never share a register in any of them.
    localparam ctl_t CTL_NONE = '0;
    localparam ctl_t CTL_LOAD = '{pc_hold: 1'b1, ifid_hold: 1'b1, idex_flush: 1'b1, default: 1'b0};
    localparam ctl_t CTL_BRANCH = '{ifid_flush: 1'b1, idex_flush: 1'b1, exmem_flush: 1'b1, default: 1'b0};
    localparam ctl_t CTL_MEM = '{pc_hold: 1'b1, ifid_hold: 1'b1, idex_hold: 1'b1, exmem_hold: 1'b1,
                                 memwb_flush: 1'b1, default: 1'b0};
    localparam ctl_t CTL_TIMEOUT = '{mem_timeout: 1'b1, default: 1'b0};

    localparam logic [1:0] STALL_LAST = 2'(LOAD_STALL_CYCLES - 1);
    localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT);

    state_t     state_q, state_d;
    logic [1:0] stall_cnt_q, stall_cnt_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    ctl_t       ctl;
    logic       lu_hit;
    logic       mw;

    assign lu_hit = ex_mem_rd_en && (ex_reg_wr_addr != '0) &&
                    ((id_rs1_used && (id_rs1_addr == ex_reg_wr_addr)) ||
                     (id_rs2_used && (id_rs2_addr == ex_reg_wr_addr)));
    assign mw     = mem_req && !mem_ack;

    // State and counter registers.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
            wait_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    // Next-state and control decode; event priority is mem-wait > branch > load-use.
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        ctl         = CTL_NONE;
        unique case (state_q)
            ST_RUN: begin
                if (mw) begin
                    ctl        = CTL_MEM;
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = 8'd1;
                end else if (branch_taken) begin
                    ctl = CTL_BRANCH;
                end else if (lu_hit) begin
                    ctl = CTL_LOAD;
                    if (LOAD_STALL_CYCLES > 1) begin
                        state_d     = ST_LOAD_STALL;
                        stall_cnt_d = 2'd1;
                    end
                end
            end
            ST_LOAD_STALL: begin
                if (mw) begin
                    // Abandon the remaining bubbles; detection restarts after the wait.
                    ctl         = CTL_MEM;
                    state_d     = ST_MEM_WAIT;
                    stall_cnt_d = '0;
                    wait_cnt_d  = 8'd1;
                end else begin
                    ctl = CTL_LOAD;
                    if (stall_cnt_q == STALL_LAST) begin
                        state_d     = ST_RUN;
                        stall_cnt_d = '0;
                    end else begin
                        stall_cnt_d = stall_cnt_q + 2'd1;
                    end
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ack) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_LIMIT) begin
                    // Forced release: holds drop this cycle and the pulse flags it.
                    ctl        = CTL_TIMEOUT;
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else begin
                    ctl        = CTL_MEM;
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d     = ST_RUN;
                stall_cnt_d = '0;
                wait_cnt_d  = '0;
            end
        endcase
    end

    // Outputs are gated by rst_n so nothing leaks out while reset is held.
    assign pc_hold      = rst_n & ctl.pc_hold;
    assign ifid_hold    = rst_n & ctl.ifid_hold;
    assign ifid_flush   = rst_n & ctl.ifid_flush;
    assign idex_hold    = rst_n & ctl.idex_hold;
    assign idex_flush   = rst_n & ctl.idex_flush;
    assign exmem_hold   = rst_n & ctl.exmem_hold;
    assign exmem_flush  = rst_n & ctl.exmem_flush;
    assign memwb_flush  = rst_n & ctl.memwb_flush;
    assign mem_timeout  = rst_n & ctl.mem_timeout;
    assign hazard_state = rst_n ? state_q : 2'd0;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] flush_events_q;

    // Free-running wrapping counters of PC-stall cycles and EX/MEM flushes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_q + 32'(pc_hold);
            flush_events_q <= flush_events_q + 32'(exmem_flush);
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;
`endif

endmodule
